timer_ctrl: RTL and testbench

//   Sequencer for a prescaled event timer built from enabled-counter stages:
//   a prescaler counter gates the enable of a period counter. Accepts

---
 rtl/timer_ctrl.sv | 116 +++++++++++
 tb/tb_timer_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_ctrl.sv
// Prescaled event timer sequencer: a prescaler gates a period counter, with start/pause/abort control.
// Optional TIMER_CTRL_RESTART_EN: i_start while busy restarts the current period instead of being ignored.
module timer_ctrl #(
  parameter int PRE_WIDTH = 4,
  parameter int PRE_LIMIT = 9,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 i_sclr,
  input  logic                 i_start,
  input  logic [CNT_WIDTH-1:0] i_period,
  input  logic                 i_oneshot,
  input  logic                 i_pause,
  input  logic                 i_abort,
  output logic [1:0]           o_state,
  output logic                 o_busy,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_tick,
  output logic                 o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  localparam logic [PRE_WIDTH-1:0] PRE_TC = PRE_WIDTH'(PRE_LIMIT);

  state_t               state_q, state_d;
  logic [PRE_WIDTH-1:0] pre_q, pre_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 oneshot_q, oneshot_d;
  logic                 done_q, done_d;
  logic                 tick;
  logic                 terminal;
  logic                 start_ok;

  assign tick     = (state_q == S_RUN) && (pre_q == PRE_TC);
  assign terminal = tick && (cnt_q == period_q);

`ifdef TIMER_CTRL_RESTART_EN
  assign start_ok = i_start;
`else
  assign start_ok = i_start && (state_q == S_IDLE);
`endif

  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    oneshot_d = oneshot_q;
    done_d    = 1'b0;
    if (i_abort) begin
      state_d = S_IDLE;
      pre_d   = '0;
      cnt_d   = '0;
    end else if (start_ok) begin
      state_d   = S_RUN;
      pre_d     = '0;
      cnt_d     = '0;
      period_d  = i_period;
      oneshot_d = i_oneshot;
    end else begin
      case (state_q)
        S_RUN: begin
          // the cycle that sees i_pause still advances, so a tick here is not lost
          pre_d   = tick ? '0 : pre_q + 1'b1;
          state_d = i_pause ? S_HOLD : S_RUN;
          if (tick) begin
            if (terminal) begin
              cnt_d  = '0;
              done_d = 1'b1;
              if (oneshot_q) state_d = S_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!i_pause) state_d = S_RUN;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      state_q   <= S_IDLE;
      pre_q     <= '0;
      cnt_q     <= '0;
      period_q  <= '0;
      oneshot_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      oneshot_q <= oneshot_d;
      done_q    <= done_d;
    end
  end

  assign o_state = state_q;
  assign o_busy  = (state_q != S_IDLE);
  assign o_cnt   = cnt_q;
  assign o_tick  = tick;
  assign o_done  = done_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl; o_done timing is checked against a queue of expected cycles.
// Honours TIMER_CTRL_RESTART_EN for the restart scenario.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       i_sclr;
  logic       i_start;
  logic [7:0] i_period;
  logic       i_oneshot;
  logic       i_pause;
  logic       i_abort;
  logic [1:0] o_state;
  logic       o_busy;
  logic [7:0] o_cnt;
  logic       o_tick;
  logic       o_done;

  int checks = 0;
  int errors = 0;
  int gcyc   = 0;
  int done_q[$];
  int t0;

  timer_ctrl #(.PRE_WIDTH(4), .PRE_LIMIT(9), .CNT_WIDTH(8)) dut (
    .clk(clk), .i_sclr(i_sclr), .i_start(i_start), .i_period(i_period),
    .i_oneshot(i_oneshot), .i_pause(i_pause), .i_abort(i_abort),
    .o_state(o_state), .o_busy(o_busy), .o_cnt(o_cnt), .o_tick(o_tick),
    .o_done(o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) gcyc <= gcyc + 1;

  // completion pulses are matched against the cycles queued when each run was started
  always @(negedge clk) begin
    if (o_done === 1'b1) begin
      checks++;
      assert (done_q.size() != 0) else begin
        errors++;
        $error("FAIL done_unexpected observed cycle %0d expected no pulse", gcyc);
      end
      if (done_q.size() != 0) begin
        int e;
        e = done_q.pop_front();
        assert (gcyc === e) else begin
          errors++;
          $error("FAIL done_cycle observed %0d expected %0d", gcyc, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic go(input int tgt);
    while (gcyc < tgt) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_run(input logic [7:0] per, input logic os);
    i_start   = 1'b1;
    i_period  = per;
    i_oneshot = os;
    t0        = gcyc;
    @(posedge clk);
    #1;
    i_start   = 1'b0;
  endtask

  initial begin
    i_sclr = 1'b1; i_start = 1'b0; i_period = '0; i_oneshot = 1'b0;
    i_pause = 1'b0; i_abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", o_state, 2'b00);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_cnt", o_cnt, 8'd0);
    chk("rst_tick", o_tick, 1'b0);
    chk("rst_done", o_done, 1'b0);
    i_sclr = 1'b0;
    go(gcyc + 2);

    // one-shot, period 2
    done_q.push_back(gcyc + 31);
    start_run(8'd2, 1'b1);
    i_period = 8'd50;
    i_oneshot = 1'b0;
    chk("os_state_c1", o_state, 2'b01);
    chk("os_busy_c1", o_busy, 1'b1);
    go(t0 + 9);  chk("os_tick_c9", o_tick, 1'b0);
    go(t0 + 10); chk("os_tick_c10", o_tick, 1'b1); chk("os_cnt_c10", o_cnt, 8'd0);
    go(t0 + 11); chk("os_cnt_c11", o_cnt, 8'd1);
    go(t0 + 20); chk("os_tick_c20", o_tick, 1'b1);
    go(t0 + 30); chk("os_tick_c30", o_tick, 1'b1); chk("os_cnt_c30", o_cnt, 8'd2);
    go(t0 + 31); chk("os_done_c31", o_done, 1'b1); chk("os_busy_c31", o_busy, 1'b0);
    chk("os_cnt_c31", o_cnt, 8'd0);
    go(t0 + 32); chk("os_done_c32", o_done, 1'b0);
    go(t0 + 35);

    // periodic, period 0
    done_q.push_back(gcyc + 11);
    done_q.push_back(gcyc + 21);
    done_q.push_back(gcyc + 31);
    start_run(8'd0, 1'b0);
    go(t0 + 11); chk("per_done_c11", o_done, 1'b1); chk("per_cnt_c11", o_cnt, 8'd0);
    go(t0 + 12); chk("per_done_c12", o_done, 1'b0);
    go(t0 + 31); chk("per_busy_c31", o_busy, 1'b1); chk("per_cnt_c31", o_cnt, 8'd0);
    go(t0 + 35);
    i_abort = 1'b1; go(t0 + 36); i_abort = 1'b0;
    chk("per_abort_state", o_state, 2'b00);
    go(t0 + 45);

    // pause cycles 5..24, period 1
    done_q.push_back(gcyc + 41);
    start_run(8'd1, 1'b1);
    go(t0 + 5); i_pause = 1'b1;
    go(t0 + 6);  chk("pz_state_c6", o_state, 2'b10); chk("pz_busy_c6", o_busy, 1'b1);
    go(t0 + 10); chk("pz_tick_c10", o_tick, 1'b0);
    go(t0 + 25); i_pause = 1'b0;
    chk("pz_cnt_c25", o_cnt, 8'd0);
    go(t0 + 26); chk("pz_state_c26", o_state, 2'b01);
    go(t0 + 29); chk("pz_tick_c29", o_tick, 1'b0);
    go(t0 + 30); chk("pz_tick_c30", o_tick, 1'b1);
    go(t0 + 31); chk("pz_cnt_c31", o_cnt, 8'd1);
    go(t0 + 42); chk("pz_state_c42", o_state, 2'b00);

    // abort in cycle 15 of a period-3 run
    start_run(8'd3, 1'b0);
    go(t0 + 15); chk("ab_cnt_c15", o_cnt, 8'd1);
    i_abort = 1'b1;
    go(t0 + 16); i_abort = 1'b0;
    chk("ab_state_c16", o_state, 2'b00); chk("ab_cnt_c16", o_cnt, 8'd0);
    go(t0 + 50); chk("ab_busy_c50", o_busy, 1'b0);
    i_start = 1'b1; i_abort = 1'b1; i_period = 8'd1;
    go(gcyc + 1);
    i_start = 1'b0; i_abort = 1'b0;
    chk("ab_sa_state", o_state, 2'b00);
    go(gcyc + 15); chk("ab_sa_busy", o_busy, 1'b0);

    // synchronous reset mid-run
    start_run(8'd5, 1'b1);
    go(t0 + 12); chk("sr_cnt_c12", o_cnt, 8'd1);
    i_sclr = 1'b1;
    go(t0 + 13); i_sclr = 1'b0;
    chk("sr_state", o_state, 2'b00); chk("sr_cnt", o_cnt, 8'd0);
    chk("sr_busy", o_busy, 1'b0); chk("sr_tick", o_tick, 1'b0);
    go(t0 + 80); chk("sr_idle_c80", o_state, 2'b00);

    // period 255 wrap
    done_q.push_back(gcyc + 2561);
    start_run(8'd255, 1'b1);
    go(t0 + 2551); chk("wr_cnt_c2551", o_cnt, 8'd255);
    go(t0 + 2560); chk("wr_tick_c2560", o_tick, 1'b1);
    go(t0 + 2561); chk("wr_cnt_c2561", o_cnt, 8'd0); chk("wr_done_c2561", o_done, 1'b1);
    chk("wr_state_c2561", o_state, 2'b00);
    go(t0 + 2565);

    // i_start while running
    start_run(8'd3, 1'b0);
    go(t0 + 15); i_start = 1'b1;
    go(t0 + 16); i_start = 1'b0;
    chk("rs_state_c16", o_state, 2'b01);
`ifdef TIMER_CTRL_RESTART_EN
    chk("rs_cnt_c16", o_cnt, 8'd0);
    go(t0 + 20); chk("rs_tick_c20", o_tick, 1'b0);
    go(t0 + 25); chk("rs_tick_c25", o_tick, 1'b1);
`else
    chk("rs_cnt_c16", o_cnt, 8'd1);
    go(t0 + 20); chk("rs_tick_c20", o_tick, 1'b1);
    go(t0 + 25); chk("rs_tick_c25", o_tick, 1'b0);
`endif
    go(t0 + 30); i_abort = 1'b1;
    go(t0 + 31); i_abort = 1'b0;
    chk("rs_abort_state", o_state, 2'b00);
    go(t0 + 60);

    checks++;
    assert (done_q.size() == 0) else begin
      errors++;
      $error("FAIL done_missing observed %0d pending expected 0", done_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
